// File: rtl/ft2232_pkg.sv
// Shared definitions for the FT2232 FT245-style FIFO bridge:
// FSM encoding, default timing and a constant clog2 helper.
package ft2232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_RD_RECOVER,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_WR_RECOVER,
        ST_SI_PULSE
    } state_t;

    localparam int DEF_TX_DEPTH  = 16;
    localparam int DEF_RX_DEPTH  = 16;
    localparam int DEF_RD_STROBE = 4;
    localparam int DEF_WR_SETUP  = 2;
    localparam int DEF_WR_STROBE = 4;
    localparam int DEF_RECOVER   = 6;
    localparam int DEF_SI_IDLE   = 64;
    localparam int DEF_SI_PULSE  = 4;

    // Width of the phase and SI idle counters.
    localparam int CNT_W = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ft2232_sync_fifo.sv
// First-word-fall-through synchronous FIFO used for both byte
// directions of the FT2232 bridge.
module ft2232_sync_fifo
    import ft2232_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so the pointers wrap on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ft2232_fifo_bridge.sv
// FT2232 FT245-style async FIFO bridge: buffered RX/TX byte pipes,
// programmable strobe timing, round-robin access and Send-Immediate.
module ft2232_fifo_bridge
    import ft2232_pkg::*;
#(
    parameter  int TX_DEPTH  = DEF_TX_DEPTH,
    parameter  int RX_DEPTH  = DEF_RX_DEPTH,
    parameter  int RD_STROBE = DEF_RD_STROBE,
    parameter  int WR_SETUP  = DEF_WR_SETUP,
    parameter  int WR_STROBE = DEF_WR_STROBE,
    parameter  int RECOVER   = DEF_RECOVER,
    parameter  int SI_IDLE   = DEF_SI_IDLE,
    parameter  int SI_PULSE  = DEF_SI_PULSE,
    localparam int TXL_W     = clog2(TX_DEPTH) + 1,
    localparam int RXL_W     = clog2(RX_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             nrxf_i,
    input  logic             ntxe_i,
    output logic             nrd_o,
    output logic             wr_o,
    output logic             nsi_o,
    inout  wire  [7:0]       d_io,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic [TXL_W-1:0] tx_level_o,
    output logic [RXL_W-1:0] rx_level_o
);

    localparam logic [CNT_W-1:0] RD_LD  = CNT_W'(RD_STROBE - 1);
    localparam logic [CNT_W-1:0] WS_LD  = CNT_W'(WR_SETUP - 1);
    localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_STROBE - 1);
    localparam logic [CNT_W-1:0] REC_LD = CNT_W'(RECOVER - 1);
    localparam logic [CNT_W-1:0] SIP_LD = CNT_W'(SI_PULSE - 1);
    localparam bit               SI_EN  = (SI_IDLE != 0);
    localparam logic [CNT_W-1:0] SI_SAT = CNT_W'(SI_EN ? SI_IDLE : 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] si_cnt;
    logic [1:0]       rxf_sync;
    logic [1:0]       txe_sync;
    logic             nrxf_s;
    logic             ntxe_s;
    logic             drive;
    logic [7:0]       dout;
    logic             prio_rx;
    logic             si_armed;

    logic             tx_full;
    logic             tx_empty;
    logic             rx_full;
    logic             rx_empty;
    logic [7:0]       tx_head;
    logic             tx_push;
    logic             tx_pop;
    logic             rx_push;
    logic             rd_ok;
    logic             wr_ok;
    logic             wr_busy;
    logic             si_go;

    assign d_io       = drive ? dout : 8'hzz;
    assign tx_ready_o = !tx_full;
    assign rx_valid_o = !rx_empty;
    assign tx_push    = tx_valid_i && !tx_full;
    assign tx_pop     = (state == ST_WR_HOLD);
    assign rx_push    = (state == ST_RD_STROBE) && (cnt == '0);
    assign nrxf_s     = rxf_sync[1];
    assign ntxe_s     = txe_sync[1];
    assign rd_ok      = !nrxf_s && !rx_full;
    assign wr_ok      = !ntxe_s && !tx_empty;
    assign wr_busy    = state inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD};
    assign si_go      = SI_EN && si_armed && tx_empty && !ntxe_s
                        && (si_cnt >= SI_SAT);

    ft2232_sync_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (tx_valid_i),
        .din   (tx_data_i),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level_o)
    );

    // The RX slot is reserved when the read starts, so the push never drops.
    ft2232_sync_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (rx_push),
        .din   (d_io),
        .pop   (rx_ready_i),
        .dout  (rx_data_o),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rxf_sync <= 2'b11;
            txe_sync <= 2'b11;
        end else begin
            rxf_sync <= {rxf_sync[0], nrxf_i};
            txe_sync <= {txe_sync[0], ntxe_i};
        end
    end

    // Counts quiet cycles since the last TX push or write activity.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            si_cnt <= '0;
        end else if (tx_push || wr_busy) begin
            si_cnt <= '0;
        end else if (si_cnt < SI_SAT) begin
            si_cnt <= si_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            nrd_o    <= 1'b1;
            wr_o     <= 1'b0;
            nsi_o    <= 1'b1;
            drive    <= 1'b0;
            dout     <= '0;
            prio_rx  <= 1'b1;
            si_armed <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (rd_ok && (!wr_ok || prio_rx)) begin
                        state   <= ST_RD_STROBE;
                        nrd_o   <= 1'b0;
                        cnt     <= RD_LD;
                        prio_rx <= 1'b0;
                    end else if (wr_ok) begin
                        state   <= ST_WR_SETUP;
                        drive   <= 1'b1;
                        dout    <= tx_head;
                        cnt     <= WS_LD;
                        prio_rx <= 1'b1;
                    end else if (si_go) begin
                        state <= ST_SI_PULSE;
                        nsi_o <= 1'b0;
                        cnt   <= SIP_LD;
                    end
                end
                ST_RD_STROBE: begin
                    if (cnt == '0) begin
                        state <= ST_RD_RECOVER;
                        nrd_o <= 1'b1;
                        cnt   <= REC_LD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RD_RECOVER: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WR_SETUP: begin
                    if (cnt == '0) begin
                        state <= ST_WR_STROBE;
                        wr_o  <= 1'b1;
                        cnt   <= WR_LD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WR_STROBE: begin
                    if (cnt == '0) begin
                        state <= ST_WR_HOLD;
                        wr_o  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WR_HOLD: begin
                    state    <= ST_WR_RECOVER;
                    drive    <= 1'b0;
                    si_armed <= 1'b1;
                    cnt      <= REC_LD;
                end
                ST_WR_RECOVER: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_SI_PULSE: begin
                    if (cnt == '0) begin
                        state    <= ST_IDLE;
                        nsi_o    <= 1'b1;
                        si_armed <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft2232_fifo_bridge.sv
// Self-checking bench for ft2232_fifo_bridge with an FT2232 host model
// and TX/RX scoreboards.
module tb_ft2232_fifo_bridge;

    logic       clk_i      = 1'b0;
    logic       reset_i    = 1'b1;
    logic       nrxf_i     = 1'b1;
    logic       ntxe_i     = 1'b1;
    logic [7:0] tx_data_i  = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       rx_ready_i = 1'b0;
    wire  [7:0] d_io;
    wire  [7:0] d_io2;
    logic       nrd_o, wr_o, nsi_o, tx_ready_o, rx_valid_o;
    logic [7:0] rx_data_o;
    logic [4:0] tx_level_o, rx_level_o;
    logic       nrd2, wr2, nsi2, txr2, rxv2;
    logic [7:0] rxd2;
    logic [4:0] txl2, rxl2;

    logic       host_drv  = 1'b0;
    logic [7:0] host_byte = 8'h00;
    bit         host_en   = 1'b0;
    logic [7:0] host_q[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_q[$];
    logic [7:0] acc_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int reads    = 0;
    int cyc      = 0;
    int wr_hi    = 0;
    int nrd_lo   = 0;
    int nsi_lo   = 0;
    int t_end    = 0;
    int t_pop    = 0;
    int nsi_falls  = 0;
    int nosi_falls = 0;
    bit have_prev  = 0;
    bit acc_on     = 0;
    bit exact_setup = 0;
    logic       wr_p = 0, nrd_p = 1, nsi_p = 1, nsi2_p = 1;
    logic [4:0] lvl_p = 0;
    logic [7:0] d_h1 = 0, d_h2 = 0, d_h3 = 0;

    assign d_io = host_drv ? host_byte : 8'hzz;

    ft2232_fifo_bridge dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .nrxf_i     (nrxf_i),
        .ntxe_i     (ntxe_i),
        .nrd_o      (nrd_o),
        .wr_o       (wr_o),
        .nsi_o      (nsi_o),
        .d_io       (d_io),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .tx_level_o (tx_level_o),
        .rx_level_o (rx_level_o)
    );

    ft2232_fifo_bridge #(.SI_IDLE(0)) dut_nosi (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .nrxf_i     (nrxf_i),
        .ntxe_i     (ntxe_i),
        .nrd_o      (nrd2),
        .wr_o       (wr2),
        .nsi_o      (nsi2),
        .d_io       (d_io2),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (txr2),
        .rx_data_o  (rxd2),
        .rx_valid_o (rxv2),
        .rx_ready_i (rx_ready_i),
        .tx_level_o (txl2),
        .rx_level_o (rxl2)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic host_upd();
        nrxf_i = !(host_en && host_q.size() != 0);
    endtask

    task automatic host_load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            host_q.push_back(base + 8'(i));
            rx_exp.push_back(base + 8'(i));
        end
        host_upd();
    endtask

    task automatic push_tx(input logic [7:0] b);
        int n = 0;
        step();
        while (!tx_ready_o && n < 2000) begin
            step();
            n++;
        end
        check("push_to", n < 2000, 1);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        tx_q.push_back(b);
        step();
        tx_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        step();
        reset_i    = 1'b1;
        tx_valid_i = 1'b0;
        rx_ready_i = 1'b0;
        repeat (3) step();
        tx_q.delete();
        rx_exp.delete();
        host_q.delete();
        host_en = 0;
        host_upd();
        reset_i = 1'b0;
    endtask

    task automatic wait_tx_drain(input string tag);
        int n = 0;
        while ((tx_q.size() != 0 || tx_level_o != 0) && n < 3000) begin
            step();
            n++;
        end
        check(tag, n < 3000, 1);
    endtask

    // FT2232 host: presents the next byte while RD# is low.
    initial forever begin
        @(negedge nrd_o);
        host_byte = (host_q.size() != 0) ? host_q[0] : 8'hEE;
        host_drv  = 1'b1;
        @(posedge nrd_o or posedge reset_i);
        host_drv = 1'b0;
        if (!reset_i && host_q.size() != 0) host_q.delete(0);
        reads++;
        host_upd();
    end

    initial forever begin
        logic [31:0] e;
        @(negedge clk_i);
        cyc++;
        if (reset_i) begin
            wr_hi = 0;
            nrd_lo = 0;
            nsi_lo = 0;
            have_prev = 0;
        end else begin
            if (wr_o) wr_hi++;
            if (!nrd_o) nrd_lo++;
            if (!nsi_o) nsi_lo++;
            if (!wr_p && wr_o) begin
                e = (tx_q.size() != 0) ? {24'd0, tx_q[0]} : 32'hDEAD;
                check("wr_setup1", {24'd0, d_h1}, e);
                check("wr_setup2", {24'd0, d_h2}, e);
                if (exact_setup) check("wr_setup_len", d_h3 === 8'hA5, 0);
                if (have_prev) check("gap_wr", (cyc - t_end) >= 6, 1);
                if (acc_on) acc_q.push_back("W");
            end
            if (wr_p && !wr_o) begin
                check("wr_width", wr_hi, 4);
                if (tx_q.size() != 0) e = {24'd0, tx_q.pop_front()};
                else e = 32'hDEAD;
                check("wr_data", {24'd0, d_io}, e);
                wr_hi = 0;
                t_end = cyc;
                have_prev = 1;
            end
            if (nrd_p && !nrd_o) begin
                if (have_prev) check("gap_rd", (cyc - t_end) >= 6, 1);
                if (acc_on) acc_q.push_back("R");
            end
            if (!nrd_p && nrd_o) begin
                check("rd_width", nrd_lo, 4);
                nrd_lo = 0;
                t_end = cyc;
                have_prev = 1;
            end
            if (nsi_p && !nsi_o) begin
                nsi_falls++;
                check($sformatf("si_delay_%0d", cyc - t_pop),
                      (cyc - t_pop) >= 64 && (cyc - t_pop) <= 66, 1);
            end
            if (!nsi_p && nsi_o) begin
                check("si_width", nsi_lo, 4);
                nsi_lo = 0;
            end
            if (rx_valid_o && rx_ready_i) begin
                if (rx_exp.size() != 0) e = {24'd0, rx_exp.pop_front()};
                else e = 32'hDEAD;
                check("rx_data", {24'd0, rx_data_o}, e);
            end
            if (tx_level_o < lvl_p) t_pop = cyc;
            if (nsi2_p && !nsi2) nosi_falls++;
        end
        d_h3 = d_h2;
        d_h2 = d_h1;
        d_h1 = d_io;
        wr_p = wr_o;
        nrd_p = nrd_o;
        nsi_p = nsi_o;
        nsi2_p = nsi2;
        lvl_p = tx_level_o;
    end

    initial begin
        int n;
        logic [4:0] lvl0;
        logic [7:0] ea;

        // 1: reset values and a single write
        host_drv  = 1'b1;
        host_byte = 8'h3C;
        repeat (3) step();
        check("rst_nrd", nrd_o, 1);
        check("rst_wr", wr_o, 0);
        check("rst_nsi", nsi_o, 1);
        check("rst_dz", d_io, 8'h3C);
        check("rst_rxv", rx_valid_o, 0);
        check("rst_txr", tx_ready_o, 1);
        check("rst_txl", tx_level_o, 0);
        check("rst_rxl", rx_level_o, 0);
        host_drv = 1'b0;
        reset_i  = 1'b0;
        ntxe_i   = 1'b0;
        exact_setup = 1;
        push_tx(8'hA5);
        wait_tx_drain("t1_drain");
        exact_setup = 0;
        check("t1_txl", tx_level_o, 0);

        // 2: RX fills, stops at depth, resumes after pops
        ntxe_i  = 1'b1;
        host_en = 1;
        host_load(20, 8'h01);
        n = 0;
        while (reads < 16 && n < 1000) begin step(); n++; end
        check("t2_to", n < 1000, 1);
        repeat (100) step();
        check("t2_reads16", reads, 16);
        check("t2_rxl16", rx_level_o, 16);
        check("t2_nrd_hi", nrd_o, 1);
        rx_ready_i = 1'b1;
        repeat (4) step();
        rx_ready_i = 1'b0;
        repeat (200) step();
        check("t2_reads20", reads, 20);
        check("t2_rxl_after", rx_level_o, 16);
        rx_ready_i = 1'b1;
        n = 0;
        while (rx_valid_o && n < 100) begin step(); n++; end
        rx_ready_i = 1'b0;
        check("t2_rx_left", rx_exp.size(), 0);

        // 3: round-robin between RD and WR
        do_reset();
        ntxe_i = 1'b1;
        for (int i = 0; i < 8; i++) push_tx(8'h40 + 8'(i));
        host_load(8, 8'h80);
        acc_q.delete();
        acc_on     = 1;
        rx_ready_i = 1'b1;
        host_en    = 1;
        host_upd();
        ntxe_i = 1'b0;
        n = 0;
        while ((tx_q.size() != 0 || host_q.size() != 0) && n < 2000) begin
            step();
            n++;
        end
        check("t3_to", n < 2000, 1);
        repeat (20) step();
        acc_on = 0;
        check("t3_nacc", acc_q.size(), 16);
        for (int i = 0; i < acc_q.size(); i++) begin
            ea = (i % 2 == 0) ? "R" : "W";
            check($sformatf("t3_alt%0d", i), acc_q[i], ea);
        end
        check("t3_rx_left", rx_exp.size(), 0);

        // 4: Send-Immediate timing and restart on a new byte
        do_reset();
        ntxe_i = 1'b0;
        nsi_falls = 0;
        push_tx(8'h11);
        wait_tx_drain("t4_drain1");
        repeat (30) step();
        push_tx(8'h22);
        wait_tx_drain("t4_drain2");
        repeat (150) step();
        check("t4_si_once", nsi_falls, 1);
        check("t4_nsi_hi", nsi_o, 1);

        // 5: reset in the middle of a write strobe
        do_reset();
        ntxe_i = 1'b0;
        push_tx(8'h5C);
        n = 0;
        while (!wr_o && n < 200) begin step(); n++; end
        check("t5_to", n < 200, 1);
        step();
        reset_i   = 1'b1;
        host_drv  = 1'b1;
        host_byte = 8'h3C;
        #1;
        check("t5_wr0", wr_o, 0);
        check("t5_dz", d_io, 8'h3C);
        check("t5_txl", tx_level_o, 0);
        check("t5_rxl", rx_level_o, 0);
        tx_q.delete();
        repeat (3) step();
        host_drv = 1'b0;
        reset_i  = 1'b0;
        push_tx(8'h77);
        wait_tx_drain("t5_drain");

        // 6: TX full, push+pop in WR_HOLD, pointer wrap
        do_reset();
        ntxe_i = 1'b1;
        for (int i = 0; i < 16; i++) push_tx(8'(i));
        check("t6_ready0", tx_ready_o, 0);
        check("t6_full", tx_level_o, 16);
        tx_data_i  = 8'hFF;
        tx_valid_i = 1'b1;
        step();
        tx_valid_i = 1'b0;
        step();
        check("t6_ignored", tx_level_o, 16);
        ntxe_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!wr_o && n < 200) begin step(); n++; end
            while (wr_o && n < 200) begin step(); n++; end
            check("t6_hold_to", n < 200, 1);
        end
        lvl0       = tx_level_o;
        tx_data_i  = 8'd16;
        tx_valid_i = 1'b1;
        tx_q.push_back(8'd16);
        step();
        tx_valid_i = 1'b0;
        check("t6_pushpop", tx_level_o, lvl0);
        for (int i = 17; i < 48; i++) push_tx(8'(i));
        wait_tx_drain("t6_drain");
        check("t6_txl0", tx_level_o, 0);
        repeat (120) step();

        check("nosi_never", nosi_falls, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
